// File: rtl/topsort_pkg.sv
// Shared types and helpers for the streaming merge-sort blocks.
package topsort_pkg;

    typedef enum logic [1:0] {
        PRIME = 2'd0,
        MERGE = 2'd1,
        FLUSH = 2'd2
    } state_e;

    // Widest key the compare helpers handle; narrower keys are zero-extended.
    localparam int KEY_MAX = 64;

    // Ceiling log2, evaluated at elaboration time.
    function automatic int log2(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < n) r = i + 1;
        end
        return r;
    endfunction

    function automatic int bundle_bits(input int data_width, input int bundle_width);
        return data_width * bundle_width;
    endfunction

    // Keep only the low key_width bits of a record as its sort key.
    function automatic logic [KEY_MAX-1:0] key_of(input logic [KEY_MAX-1:0] rec, input int key_width);
        logic [KEY_MAX-1:0] k;
        for (int i = 0; i < KEY_MAX; i++) begin
            k[i] = (i < key_width) ? rec[i] : 1'b0;
        end
        return k;
    endfunction

    // True when key a must be placed strictly before key b.
    function automatic logic ordered_lt(input logic [KEY_MAX-1:0] a, input logic [KEY_MAX-1:0] b,
                                        input logic descending);
        return descending ? (a > b) : (a < b);
    endfunction

endpackage

// File: rtl/bitonic_merge_comb.sv
// Combinational bitonic merger: merges two sorted bundles into a sorted
// 2*BUNDLE_WIDTH sequence and returns its lower and upper halves.
module bitonic_merge_comb
    import topsort_pkg::*;
#(
    parameter int DATA_WIDTH   = 32,
    parameter int KEY_WIDTH    = 32,
    parameter int BUNDLE_WIDTH = 16,
    parameter bit DESCENDING   = 1'b0
) (
    input  logic [DATA_WIDTH*BUNDLE_WIDTH-1:0] fb,
    input  logic [DATA_WIDTH*BUNDLE_WIDTH-1:0] in_bundle,
    output logic [DATA_WIDTH*BUNDLE_WIDTH-1:0] lo,
    output logic [DATA_WIDTH*BUNDLE_WIDTH-1:0] hi
);
    localparam int DW     = DATA_WIDTH;
    localparam int N      = BUNDLE_WIDTH;
    localparam int LAYERS = log2(N) + 1;

    // fb followed by the reversed input bundle is bitonic; half-cleaner layers
    // with halving distance sort it completely.
    always_comb begin
        logic [DW-1:0] net [2*N];
        logic [DW-1:0] t;
        int d;
        int i;
        int j;
        t = '0;
        for (int k = 0; k < N; k++) begin
            net[k]         = fb[k*DW +: DW];
            net[2*N-1-k]   = in_bundle[k*DW +: DW];
        end
        for (int s = 0; s < LAYERS; s++) begin
            d = N >> s;
            for (int p = 0; p < N; p++) begin
                i = (p / d) * 2 * d + (p % d);
                j = i + d;
                if (ordered_lt(key_of(KEY_MAX'(net[j]), KEY_WIDTH),
                               key_of(KEY_MAX'(net[i]), KEY_WIDTH), DESCENDING)) begin
                    t      = net[i];
                    net[i] = net[j];
                    net[j] = t;
                end
            end
        end
        for (int k = 0; k < N; k++) begin
            lo[k*DW +: DW] = net[k];
            hi[k*DW +: DW] = net[N+k];
        end
    end

endmodule

// File: rtl/bitonic_merge_stream.sv
// Streaming two-way merge node: keeps the larger half of every merge step in
// a feedback register and emits the smaller half through a 2-entry skid FIFO.
module bitonic_merge_stream
    import topsort_pkg::*;
#(
    parameter int DATA_WIDTH   = 32,
    parameter int KEY_WIDTH    = 32,
    parameter int BUNDLE_WIDTH = 16,
    parameter bit DESCENDING   = 1'b0
) (
    input  logic                                i_clk,
    input  logic                                i_rst,
    input  logic                                i_valid_a,
    input  logic [DATA_WIDTH*BUNDLE_WIDTH-1:0]  i_bundle_a,
    input  logic                                i_last_a,
    output logic                                o_ready_a,
    input  logic                                i_valid_b,
    input  logic [DATA_WIDTH*BUNDLE_WIDTH-1:0]  i_bundle_b,
    input  logic                                i_last_b,
    output logic                                o_ready_b,
    output logic                                o_valid,
    output logic [DATA_WIDTH*BUNDLE_WIDTH-1:0]  o_bundle,
    output logic                                o_last,
    input  logic                                i_ready
);
    localparam int DW          = DATA_WIDTH;
    localparam int BUNDLE_BITS = bundle_bits(DATA_WIDTH, BUNDLE_WIDTH);

    state_e                 st;
    logic [BUNDLE_BITS-1:0] fb;
    logic                   done_a;
    logic                   done_b;

    logic [BUNDLE_BITS-1:0] fifo_data [2];
    logic                   fifo_last [2];
    logic                   rd_ptr;
    logic                   wr_ptr;
    logic [1:0]             count;

    logic                   pop;
    logic                   space;
    logic                   a_first;
    logic                   sel_a;
    logic                   prime_fire;
    logic                   step;
    logic                   push;
    logic                   push_last;
    logic [BUNDLE_BITS-1:0] push_data;
    logic [BUNDLE_BITS-1:0] sel_bundle;
    logic [BUNDLE_BITS-1:0] lo;
    logic [BUNDLE_BITS-1:0] hi;

    assign pop   = (count != 2'd0) && i_ready;
    assign space = (count < 2'd2) || pop;

    // Ties between the two heads go to stream A.
    assign a_first = !ordered_lt(key_of(KEY_MAX'(i_bundle_b[DW-1:0]), KEY_WIDTH),
                                 key_of(KEY_MAX'(i_bundle_a[DW-1:0]), KEY_WIDTH), DESCENDING);

    assign sel_bundle = sel_a ? i_bundle_a : i_bundle_b;

    bitonic_merge_comb #(
        .DATA_WIDTH   (DATA_WIDTH),
        .KEY_WIDTH    (KEY_WIDTH),
        .BUNDLE_WIDTH (BUNDLE_WIDTH),
        .DESCENDING   (DESCENDING)
    ) u_merge (
        .fb        (fb),
        .in_bundle (sel_bundle),
        .lo        (lo),
        .hi        (hi)
    );

    // Stream selection, step qualification, FIFO push and ready generation.
    always_comb begin
        sel_a      = a_first;
        prime_fire = 1'b0;
        step       = 1'b0;
        push       = 1'b0;
        push_last  = 1'b0;
        push_data  = lo;
        if (done_b)      sel_a = 1'b1;
        else if (done_a) sel_a = 1'b0;
        case (st)
            PRIME: prime_fire = i_valid_a && i_valid_b;
            MERGE: begin
                if (done_a || done_b) step = space && (sel_a ? i_valid_a : i_valid_b);
                else                  step = space && i_valid_a && i_valid_b;
                push = step;
            end
            FLUSH: begin
                push      = space;
                push_last = 1'b1;
                push_data = fb;
            end
            default: ;
        endcase
        o_ready_a = !i_rst && (prime_fire || step) && sel_a;
        o_ready_b = !i_rst && (prime_fire || step) && !sel_a;
    end

    // Merge control FSM and feedback register.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            st     <= PRIME;
            fb     <= '0;
            done_a <= 1'b0;
            done_b <= 1'b0;
        end else begin
            case (st)
                PRIME: if (prime_fire) begin
                    fb <= sel_bundle;
                    if (sel_a) done_a <= i_last_a;
                    else       done_b <= i_last_b;
                    st <= MERGE;
                end
                MERGE: if (step) begin
                    fb <= hi;
                    if (sel_a) begin
                        done_a <= i_last_a;
                        if (i_last_a && done_b) st <= FLUSH;
                    end else begin
                        done_b <= i_last_b;
                        if (i_last_b && done_a) st <= FLUSH;
                    end
                end
                FLUSH: if (space) begin
                    done_a <= 1'b0;
                    done_b <= 1'b0;
                    st     <= PRIME;
                end
                default: st <= PRIME;
            endcase
        end
    end

    // Two-entry skid FIFO; its head is the registered output.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
            count  <= 2'd0;
            for (int k = 0; k < 2; k++) begin
                fifo_data[k] <= '0;
                fifo_last[k] <= 1'b0;
            end
        end else begin
            if (push) begin
                fifo_data[wr_ptr] <= push_data;
                fifo_last[wr_ptr] <= push_last;
                wr_ptr            <= ~wr_ptr;
            end
            if (pop) rd_ptr <= ~rd_ptr;
            count <= count + {1'b0, push} - {1'b0, pop};
        end
    end

    assign o_valid  = (count != 2'd0);
    assign o_bundle = fifo_data[rd_ptr];
    assign o_last   = fifo_last[rd_ptr];

endmodule

// File: tb/tb_bitonic_merge_stream.sv
// Directed bench for bitonic_merge_stream with 4 x 8-bit records per bundle.
module tb_bitonic_merge_stream;
    localparam int DW = 8;
    localparam int BW = 4;
    localparam int BB = DW * BW;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst = 1'b0;
    logic          va = 1'b0, la = 1'b0, vb = 1'b0, lb = 1'b0, ir = 1'b0;
    logic [BB-1:0] ba = '0, bb = '0;
    logic          ra0, rb0, ov0, ol0, ra1, rb1, ov1, ol1;
    logic [BB-1:0] ob0, ob1;
    logic          use_desc = 1'b0;
    logic          ra, rb, ov, ol;
    logic [BB-1:0] ob;

    assign ra = use_desc ? ra1 : ra0;
    assign rb = use_desc ? rb1 : rb0;
    assign ov = use_desc ? ov1 : ov0;
    assign ol = use_desc ? ol1 : ol0;
    assign ob = use_desc ? ob1 : ob0;

    bitonic_merge_stream #(.DATA_WIDTH(DW), .KEY_WIDTH(DW), .BUNDLE_WIDTH(BW), .DESCENDING(1'b0)) dut_asc (
        .i_clk(clk), .i_rst(rst),
        .i_valid_a(va), .i_bundle_a(ba), .i_last_a(la), .o_ready_a(ra0),
        .i_valid_b(vb), .i_bundle_b(bb), .i_last_b(lb), .o_ready_b(rb0),
        .o_valid(ov0), .o_bundle(ob0), .o_last(ol0), .i_ready(ir)
    );

    bitonic_merge_stream #(.DATA_WIDTH(DW), .KEY_WIDTH(DW), .BUNDLE_WIDTH(BW), .DESCENDING(1'b1)) dut_desc (
        .i_clk(clk), .i_rst(rst),
        .i_valid_a(va), .i_bundle_a(ba), .i_last_a(la), .o_ready_a(ra1),
        .i_valid_b(vb), .i_bundle_b(bb), .i_last_b(lb), .o_ready_b(rb1),
        .o_valid(ov1), .o_bundle(ob1), .o_last(ol1), .i_ready(ir)
    );

    logic [BB-1:0] qa[$], qb[$], outb[$], expb[$];
    logic          qal[$], qbl[$], outl[$], expl[$];
    int            fire_cyc[$];
    int            cyc, b_delay, stall_cnt;
    bit            stall_mode, skew_mode, seen_ov, acc_seen, first_a, first_b;
    int            n_cmp = 0;
    int            n_bad = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [BB-1:0] bund(input logic [7:0] e0, e1, e2, e3);
        return {e3, e2, e1, e0};
    endfunction

    task automatic clear_case();
        qa.delete(); qal.delete(); qb.delete(); qbl.delete();
        outb.delete(); outl.delete(); expb.delete(); expl.delete(); fire_cyc.delete();
        cyc = 0; b_delay = 0; stall_cnt = 0;
        stall_mode = 0; skew_mode = 0; seen_ov = 0; acc_seen = 0; first_a = 0; first_b = 0;
    endtask

    task automatic push_a(input logic [BB-1:0] b, input logic l); qa.push_back(b); qal.push_back(l); endtask
    task automatic push_b(input logic [BB-1:0] b, input logic l); qb.push_back(b); qbl.push_back(l); endtask
    task automatic expect_out(input logic [BB-1:0] b, input logic l); expb.push_back(b); expl.push_back(l); endtask

    task automatic do_reset();
        rst = 1'b1; va = 0; vb = 0; la = 0; lb = 0; ir = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    // One clock: drive at the falling edge, sample 1 ns later, retire after the rising edge.
    task automatic cycle();
        logic acc_a, acc_b, fire;
        @(negedge clk);
        if (qa.size() > 0) begin va = 1; ba = qa[0]; la = qal[0]; end
        else begin va = 0; ba = '0; la = 0; end
        if (qb.size() > 0 && cyc >= b_delay) begin vb = 1; bb = qb[0]; lb = qbl[0]; end
        else begin vb = 0; bb = '0; lb = 0; end
        if (stall_mode && !seen_ov && ov) begin seen_ov = 1; stall_cnt = 5; end
        ir = (stall_cnt == 0);
        #1;
        acc_a = va & ra;
        acc_b = vb & rb;
        fire  = ov & ir;
        if (stall_cnt > 0) begin
            chk("bp_hold", ob, bund(1, 2, 3, 4));
            if (stall_cnt <= 4) chk("bp_ready", {ra, rb}, 2'b00);
            stall_cnt--;
        end
        if (skew_mode && !vb) chk("skew_no_a", acc_a, 1'b0);
        if (!acc_seen && (acc_a || acc_b)) begin acc_seen = 1; first_a = acc_a; first_b = acc_b; end
        if (fire) begin outb.push_back(ob); outl.push_back(ol); fire_cyc.push_back(cyc); end
        @(posedge clk);
        if (acc_a) begin void'(qa.pop_front()); void'(qal.pop_front()); end
        if (acc_b) begin void'(qb.pop_front()); void'(qbl.pop_front()); end
        cyc++;
    endtask

    task automatic run_case(input string tag, input int n_exp);
        int budget;
        budget = 200;
        while (outb.size() < n_exp && budget > 0) begin cycle(); budget--; end
        repeat (3) cycle();
        chk({tag, "_count"}, outb.size(), n_exp);
        for (int i = 0; i < expb.size(); i++) begin
            if (i < outb.size()) begin
                chk({tag, "_data"}, outb[i], expb[i]);
                chk({tag, "_last"}, outl[i], expl[i]);
                $display("%s out[%0d] = %h last=%0d", tag, i, outb[i], outl[i]);
            end else begin
                chk({tag, "_present"}, outb.size(), i + 1);
            end
        end
    endtask

    task automatic load_basic();
        push_a(bund(1, 3, 5, 7), 0);
        push_a(bund(9, 11, 13, 15), 1);
        push_b(bund(2, 4, 6, 8), 1);
    endtask

    task automatic expect_basic();
        expect_out(bund(1, 2, 3, 4), 0);
        expect_out(bund(5, 6, 7, 8), 0);
        expect_out(bund(9, 11, 13, 15), 1);
    endtask

    initial begin
        int budget;
        // Reset state, with both valids high to show readies stay low.
        va = 1; ba = bund(1, 2, 3, 4); vb = 1; bb = bund(2, 4, 6, 8); ir = 1;
        #1 rst = 1'b1;
        #1;
        chk("rst_valid", ov, 1'b0);
        chk("rst_last", ol, 1'b0);
        chk("rst_bundle", ob, '0);
        chk("rst_ready", {ra, rb}, 2'b00);
        do_reset();

        // Basic merge.
        clear_case(); do_reset(); load_basic(); expect_basic();
        run_case("basic", 3);
        if (fire_cyc.size() > 0) chk("basic_latency", fire_cyc[0], 2);

        // Backpressure.
        clear_case(); do_reset(); load_basic(); expect_basic();
        stall_mode = 1;
        run_case("backpressure", 3);

        // Tie and skew.
        clear_case(); do_reset();
        push_a(bund(4, 4, 4, 4), 1);
        push_b(bund(4, 4, 4, 4), 1);
        expect_out(bund(4, 4, 4, 4), 0);
        expect_out(bund(4, 4, 4, 4), 1);
        skew_mode = 1; b_delay = 10;
        run_case("tie", 2);
        chk("tie_prime_a", {first_a, first_b}, 2'b10);

        // Descending order.
        use_desc = 1;
        clear_case(); do_reset();
        push_a(bund(9, 7, 5, 3), 1);
        push_b(bund(8, 6, 2, 1), 1);
        expect_out(bund(9, 8, 7, 6), 0);
        expect_out(bund(5, 3, 2, 1), 1);
        run_case("desc", 2);
        use_desc = 0;

        // Reset after the first output of a basic merge.
        clear_case(); do_reset(); load_basic();
        budget = 50;
        while (outb.size() < 1 && budget > 0) begin cycle(); budget--; end
        chk("rst_mid_first", outb.size(), 1);
        #2 rst = 1'b1;
        #1;
        chk("rst_mid_valid", ov, 1'b0);
        chk("rst_mid_last", ol, 1'b0);
        chk("rst_mid_bundle", ob, '0);
        chk("rst_mid_ready", {ra, rb}, 2'b00);
        va = 0; vb = 0;
        @(negedge clk);
        rst = 1'b0;
        clear_case();
        push_a(bund(0, 1, 2, 3), 1);
        push_b(bund(4, 5, 6, 7), 1);
        expect_out(bund(0, 1, 2, 3), 0);
        expect_out(bund(4, 5, 6, 7), 1);
        run_case("rst_fresh", 2);

        // Back-to-back pairs.
        clear_case(); do_reset();
        load_basic(); load_basic();
        expect_basic(); expect_basic();
        run_case("b2b", 6);
        if (fire_cyc.size() >= 4) chk("b2b_gap_ok", (fire_cyc[3] - fire_cyc[2]) <= 2, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
